port_bus_sequencer: RTL and testbench

//   Sequences single-beat read/write transfers on one bidirectional port_if
//   bus, for example the cartridge data bus. Drives dir_to_port/to_port and a

---
 rtl/port_bus_sequencer_if.sv | 28 ++
 rtl/port_bus_sequencer.sv | 134 +++++++++++++
 tb/tb_port_bus_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/port_bus_sequencer_if.sv
// Core-side request/response handshake plus the bidirectional bus drive/sample
// signals that feed the top-level tri-state.
interface port_bus_sequencer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_rdata;
  logic             dir_to_port;
  logic [WIDTH-1:0] to_port;
  logic [WIDTH-1:0] from_port;
  logic             port_strobe;

  // Sequencer side
  modport slave (
    input  req_valid, req_write, req_wdata, from_port,
    output req_ready, rsp_valid, rsp_rdata, dir_to_port, to_port, port_strobe
  );

  // Core / bus side
  modport master (
    output req_valid, req_write, req_wdata, from_port,
    input  req_ready, rsp_valid, rsp_rdata, dir_to_port, to_port, port_strobe
  );
endinterface

// File: rtl/port_bus_sequencer.sv
// Sequences single-beat reads/writes on a shared bidirectional port bus.
// Every read is followed by TURNAROUND idle cycles with the bus released so
// the core never drives while the external device may still be driving.
module port_bus_sequencer #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned STROBE_CYCLES = 4,
  parameter int unsigned TURNAROUND    = 2
) (
  input logic                 clk,
  input logic                 reset,
  port_bus_sequencer_if.slave bus
);

  localparam logic [7:0] STROBE_RELOAD = 8'(STROBE_CYCLES - 1);
  localparam logic [3:0] TURN_RELOAD   = (TURNAROUND > 0) ? 4'(TURNAROUND - 1) : '0;

  typedef enum logic [2:0] {
    IDLE,
    W_SETUP,
    W_STROBE,
    W_HOLD,
    R_STROBE,
    R_RECOVER
  } state_t;

  state_t           state_q;
  logic [7:0]       strobe_cnt_q;
  logic [3:0]       turn_cnt_q;
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_rdata_q;
  logic             dir_q;
  logic [WIDTH-1:0] to_port_q;
  logic             strobe_q;

  // FSM with all outputs registered alongside the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      strobe_cnt_q <= '0;
      turn_cnt_q   <= '0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      dir_q        <= 1'b0;
      to_port_q    <= '0;
      strobe_q     <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            if (bus.req_write) begin
              state_q   <= W_SETUP;
              dir_q     <= 1'b1;
              to_port_q <= bus.req_wdata;
            end else begin
              state_q      <= R_STROBE;
              strobe_q     <= 1'b1;
              strobe_cnt_q <= STROBE_RELOAD;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        W_SETUP: begin
          state_q      <= W_STROBE;
          strobe_q     <= 1'b1;
          strobe_cnt_q <= STROBE_RELOAD;
        end
        W_STROBE: begin
          if (strobe_cnt_q == '0) begin
            state_q  <= W_HOLD;
            strobe_q <= 1'b0;
          end else begin
            strobe_cnt_q <= strobe_cnt_q - 8'd1;
          end
        end
        W_HOLD: begin
          state_q     <= IDLE;
          dir_q       <= 1'b0;
          to_port_q   <= '0;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= '0;
          req_ready_q <= 1'b1;
        end
        R_STROBE: begin
          if (strobe_cnt_q == '0) begin
            strobe_q    <= 1'b0;
            rsp_rdata_q <= bus.from_port;
            rsp_valid_q <= 1'b1;
            if (TURNAROUND > 0) begin
              state_q    <= R_RECOVER;
              turn_cnt_q <= TURN_RELOAD;
            end else begin
              state_q     <= IDLE;
              req_ready_q <= 1'b1;
            end
          end else begin
            strobe_cnt_q <= strobe_cnt_q - 8'd1;
          end
        end
        R_RECOVER: begin
          if (turn_cnt_q == '0) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
          end else begin
            turn_cnt_q <= turn_cnt_q - 4'd1;
          end
        end
        default: begin
          state_q     <= IDLE;
          dir_q       <= 1'b0;
          to_port_q   <= '0;
          strobe_q    <= 1'b0;
          req_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.dir_to_port = dir_q;
  assign bus.to_port     = to_port_q;
  assign bus.port_strobe = strobe_q;

  // The core must never drive the bus while the device may be driving it
  dir_never_in_read: assert property (@(posedge clk) disable iff (reset)
    ((state_q == R_STROBE) || (state_q == R_RECOVER)) |-> !dir_q);

endmodule

// File: tb/tb_port_bus_sequencer.sv
// Directed bench for port_bus_sequencer: three instances cover S=4/T=2,
// S=4/T=0 and S=1/T=2. Outputs are sampled on the falling edge.
module tb_port_bus_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0] sel;
  logic       req_valid;
  logic       req_write;
  logic [7:0] req_wdata;
  logic [7:0] from_port;

  port_bus_sequencer_if #(.WIDTH(8)) if_a ();
  port_bus_sequencer_if #(.WIDTH(8)) if_b ();
  port_bus_sequencer_if #(.WIDTH(8)) if_c ();

  port_bus_sequencer #(.WIDTH(8), .STROBE_CYCLES(4), .TURNAROUND(2)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a.slave));
  port_bus_sequencer #(.WIDTH(8), .STROBE_CYCLES(4), .TURNAROUND(0)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b.slave));
  port_bus_sequencer #(.WIDTH(8), .STROBE_CYCLES(1), .TURNAROUND(2)) dut_c (
    .clk(clk), .reset(reset), .bus(if_c.slave));

  assign if_a.req_valid = req_valid && (sel == 2'd0);
  assign if_a.req_write = req_write;
  assign if_a.req_wdata = req_wdata;
  assign if_a.from_port = from_port;
  assign if_b.req_valid = req_valid && (sel == 2'd1);
  assign if_b.req_write = req_write;
  assign if_b.req_wdata = req_wdata;
  assign if_b.from_port = from_port;
  assign if_c.req_valid = req_valid && (sel == 2'd2);
  assign if_c.req_write = req_write;
  assign if_c.req_wdata = req_wdata;
  assign if_c.from_port = from_port;

  logic       obs_dir, obs_stb, obs_rv, obs_rdy;
  logic [7:0] obs_to, obs_rd;

  always_comb begin
    obs_dir = if_a.dir_to_port; obs_stb = if_a.port_strobe; obs_to = if_a.to_port;
    obs_rv  = if_a.rsp_valid;   obs_rd  = if_a.rsp_rdata;   obs_rdy = if_a.req_ready;
    case (sel)
      2'd1: begin
        obs_dir = if_b.dir_to_port; obs_stb = if_b.port_strobe; obs_to = if_b.to_port;
        obs_rv  = if_b.rsp_valid;   obs_rd  = if_b.rsp_rdata;   obs_rdy = if_b.req_ready;
      end
      2'd2: begin
        obs_dir = if_c.dir_to_port; obs_stb = if_c.port_strobe; obs_to = if_c.to_port;
        obs_rv  = if_c.rsp_valid;   obs_rd  = if_c.rsp_rdata;   obs_rdy = if_c.req_ready;
      end
      default: ;
    endcase
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
  endtask

  task automatic cyc(input string tag, input int c, input logic edir, input logic estb,
                     input logic [7:0] eto, input logic erv, input logic erdy);
    chk($sformatf("%s c%0d dir", tag, c),    {7'b0, obs_dir}, {7'b0, edir});
    chk($sformatf("%s c%0d strobe", tag, c), {7'b0, obs_stb}, {7'b0, estb});
    chk($sformatf("%s c%0d to_port", tag, c), obs_to, eto);
    chk($sformatf("%s c%0d rsp_valid", tag, c), {7'b0, obs_rv}, {7'b0, erv});
    chk($sformatf("%s c%0d req_ready", tag, c), {7'b0, obs_rdy}, {7'b0, erdy});
  endtask

  // Presents a request in cycle 0 of a transfer; the instance must be ready
  task automatic start(input logic [1:0] s, input logic w, input logic [7:0] d);
    sel = s;
    @(negedge clk);
    chk($sformatf("start%0d ready", s), {7'b0, obs_rdy}, 8'h01);
    req_valid = 1'b1;
    req_write = w;
    req_wdata = d;
  endtask

  task automatic wait_ready(input logic [1:0] s, input int budget);
    sel = s;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (obs_rdy) break;
    end
    chk($sformatf("ready after reset %0d", s), {7'b0, obs_rdy}, 8'h01);
  endtask

  initial begin
    reset = 1'b1; sel = 2'd0; req_valid = 1'b0; req_write = 1'b0;
    req_wdata = '0; from_port = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      cyc($sformatf("reset%0d", s), 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      chk($sformatf("reset%0d rdata", s), obs_rd, 8'h00);
    end
    @(negedge clk);
    reset = 1'b0;
    wait_ready(2'd0, 5);
    wait_ready(2'd1, 5);
    wait_ready(2'd2, 5);

    // 1: write 0xA5, S=4
    start(2'd0, 1'b1, 8'hA5);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      cyc("t1", c, c <= 6, c >= 2 && c <= 5, (c <= 6) ? 8'hA5 : 8'h00, c == 7, c == 7);
      if (c == 1) req_valid = 1'b0;
    end
    chk("t1 rdata", obs_rd, 8'h00);

    // 2: read, 0x3C through cycle 4 then 0xFF
    from_port = 8'h3C;
    start(2'd0, 1'b0, 8'h00);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      cyc("t2", c, 1'b0, c <= 4, 8'h00, c == 5, c == 7);
      if (c == 5) chk("t2 rdata", obs_rd, 8'h3C);
      if (c == 1) req_valid = 1'b0;
      if (c == 5) from_port = 8'hFF;
    end

    // 3: read then write with req_valid held
    from_port = 8'h44;
    start(2'd0, 1'b0, 8'h00);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      cyc("t3", c, c >= 8 && c <= 13, (c <= 4) || (c >= 9 && c <= 12),
          (c >= 8 && c <= 13) ? 8'h5A : 8'h00, c == 5 || c == 14, c == 7 || c == 14);
      if (c == 5)  chk("t3 read rdata", obs_rd, 8'h44);
      if (c == 14) chk("t3 write rdata", obs_rd, 8'h00);
      if (c == 1) begin req_write = 1'b1; req_wdata = 8'h5A; end
      if (c == 8) req_valid = 1'b0;
    end

    // 4: reset during cycle 3 of a write, then a normal read
    start(2'd0, 1'b1, 8'h77);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c <= 3)      cyc("t4", c, 1'b1, c >= 2, 8'h77, 1'b0, 1'b0);
      else if (c == 4) cyc("t4", c, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      else begin
        chk($sformatf("t4 c%0d rsp_valid", c), {7'b0, obs_rv}, 8'h00);
        chk($sformatf("t4 c%0d dir", c), {7'b0, obs_dir}, 8'h00);
      end
      if (c == 1) req_valid = 1'b0;
      if (c == 3) reset = 1'b1;
      if (c == 4) reset = 1'b0;
    end
    from_port = 8'hC3;
    start(2'd0, 1'b0, 8'h00);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      cyc("t4r", c, 1'b0, c <= 4, 8'h00, c == 5, c == 7);
      if (c == 5) chk("t4r rdata", obs_rd, 8'hC3);
      if (c == 1) req_valid = 1'b0;
    end

    // 5: T=0, back-to-back reads
    from_port = 8'h11;
    start(2'd1, 1'b0, 8'h00);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      cyc("t5", c, 1'b0, (c <= 4) || (c >= 6 && c <= 9), 8'h00,
          c == 5 || c == 10, c == 5 || c == 10);
      if (c == 5)  chk("t5 rdata1", obs_rd, 8'h11);
      if (c == 10) chk("t5 rdata2", obs_rd, 8'h22);
      if (c == 5) from_port = 8'h22;
      if (c == 6) req_valid = 1'b0;
    end

    // 6: S=1 write then read
    start(2'd2, 1'b1, 8'h99);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      cyc("t6w", c, c <= 3, c == 2, (c <= 3) ? 8'h99 : 8'h00, c == 4, c == 4);
      if (c == 1) req_valid = 1'b0;
    end
    from_port = 8'hE7;
    start(2'd2, 1'b0, 8'h00);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      cyc("t6r", c, 1'b0, c == 1, 8'h00, c == 2, c == 4);
      if (c == 2) chk("t6r rdata", obs_rd, 8'hE7);
      if (c == 1) req_valid = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
